// File: rtl/regfile_mp_if.sv
`default_nettype none
// ============================================================================
// Module   : regfile_mp_if
// Brief    : Read/write/alloc port bundle for the multi-port register file.
// Revision : 1.0
// ============================================================================
interface regfile_mp_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NRD   = 2,
  parameter int NWR   = 2
);
  localparam int AW = $clog2(NREGS);

  logic [NRD-1:0]      rd_en;
  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_busy;
  logic [NWR-1:0]      wr_en;
  logic [NWR*AW-1:0]   wr_addr;
  logic [NWR*XLEN-1:0] wr_data;
  logic                alloc_en;
  logic [AW-1:0]       alloc_addr;
  logic                ready;

  modport master (
    output rd_en, rd_addr, wr_en, wr_addr, wr_data, alloc_en, alloc_addr,
    input  rd_data, rd_busy, ready
  );

  modport slave (
    input  rd_en, rd_addr, wr_en, wr_addr, wr_data, alloc_en, alloc_addr,
    output rd_data, rd_busy, ready
  );
endinterface
`default_nettype wire

// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
// Module   : regfile_mp
// Brief    : Multi-port register file with busy scoreboard and sequential
//            post-reset clear. Define REGFILE_BYPASS_EN for write-to-read bypass.
// Revision : 1.0
// ============================================================================
module regfile_mp #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int NRD      = 2,
  parameter int NWR      = 2,
  parameter int ZERO_REG = 1
) (
  input  logic        clk,
  input  logic        rst,
  regfile_mp_if.slave bus
);
  localparam int AW = $clog2(NREGS);

`ifdef REGFILE_BYPASS_EN
  localparam bit c_bypass = 1'b1;
`else
  localparam bit c_bypass = 1'b0;
`endif

  typedef enum logic [0:0] {
    S_INIT = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_ready;
  logic [AW-1:0]    r_cnt;
  logic [XLEN-1:0]  r_regs [NREGS];
  logic [NREGS-1:0] r_busy;
  logic [NREGS-1:0] w_busy_nxt;
  logic [NWR-1:0]   w_wr_ok;
  logic             w_alloc_ok;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_INIT;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ready     = 1'b0;
    case (r_state)
      S_INIT:  if (r_cnt == AW'(NREGS - 1)) w_state_nxt = S_RUN;
      S_RUN:   w_ready = 1'b1;
      default: w_state_nxt = S_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)                    r_cnt <= '0;
    else if (r_state == S_INIT) r_cnt <= r_cnt + AW'(1);
  end

  // Qualified write/alloc strobes: only in RUN, and never to a hardwired zero.
  always_comb begin
    for (int j = 0; j < NWR; j++) begin
      w_wr_ok[j] = w_ready && bus.wr_en[j] &&
                   !((ZERO_REG != 0) && (bus.wr_addr[j*AW +: AW] == '0));
    end
    w_alloc_ok = w_ready && bus.alloc_en &&
                 !((ZERO_REG != 0) && (bus.alloc_addr == '0));
  end

  // Ascending loop order makes the highest-indexed port's store land last.
  always_ff @(posedge clk) begin
    if (r_state == S_INIT) begin
      r_regs[r_cnt] <= '0;
    end else if (!rst) begin
      for (int j = 0; j < NWR; j++) begin
        if (w_wr_ok[j]) r_regs[bus.wr_addr[j*AW +: AW]] <= bus.wr_data[j*XLEN +: XLEN];
      end
    end
  end

  always_comb begin
    w_busy_nxt = r_busy;
    for (int j = 0; j < NWR; j++) begin
      if (w_wr_ok[j]) w_busy_nxt[bus.wr_addr[j*AW +: AW]] = 1'b0;
    end
    if (w_alloc_ok) w_busy_nxt[bus.alloc_addr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) r_busy <= '0;
    else     r_busy <= w_busy_nxt;
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0]   w_ra;
    logic [XLEN-1:0] w_rdata;
    logic            w_rbusy;

    always_comb begin
      w_ra    = bus.rd_addr[i*AW +: AW];
      w_rdata = '0;
      w_rbusy = 1'b0;
      if (w_ready && bus.rd_en[i] && !((ZERO_REG != 0) && (w_ra == '0))) begin
        w_rdata = r_regs[w_ra];
        w_rbusy = r_busy[w_ra];
        if (c_bypass) begin
          for (int j = 0; j < NWR; j++) begin
            if (w_wr_ok[j] && (bus.wr_addr[j*AW +: AW] == w_ra)) begin
              w_rdata = bus.wr_data[j*XLEN +: XLEN];
              w_rbusy = 1'b0;
            end
          end
        end
      end
    end

    assign bus.rd_data[i*XLEN +: XLEN] = w_rdata;
    assign bus.rd_busy[i]              = w_rbusy;
  end

  assign bus.ready = w_ready;
endmodule
`default_nettype wire

// File: tb/tb_regfile_mp.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_mp
// Brief    : Directed and randomized bench for regfile_mp against an array model.
// Revision : 1.0
// ============================================================================
module tb_regfile_mp;
  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int NRD   = 2;
  localparam int NWR   = 2;
  localparam int AW    = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  regfile_mp_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR)) bus ();

  regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .ZERO_REG(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: whole array cleared on reset, then NREGS dead cycles.
  logic [31:0] m_regs [NREGS];
  bit          m_busy [NREGS];
  int          m_left  = 0;
  bit          started = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      for (int a = 0; a < NREGS; a++) begin
        m_regs[a] = '0;
        m_busy[a] = 1'b0;
      end
      m_left  = NREGS;
      started = 1'b1;
    end else if (m_left > 0) begin
      m_left--;
    end else begin
      for (int j = 0; j < NWR; j++) begin
        int a;
        a = int'(bus.wr_addr[j*AW +: AW]);
        if (bus.wr_en[j] && a != 0) begin
          m_regs[a] = bus.wr_data[j*XLEN +: XLEN];
          m_busy[a] = 1'b0;
        end
      end
      if (bus.alloc_en && bus.alloc_addr != 0) m_busy[int'(bus.alloc_addr)] = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("ready", {31'b0, bus.ready}, {31'b0, (m_left == 0)});
      for (int i = 0; i < NRD; i++) begin
        int          a;
        logic [31:0] ed;
        bit          eb;
        a  = int'(bus.rd_addr[i*AW +: AW]);
        ed = '0;
        eb = 1'b0;
        if (m_left == 0 && bus.rd_en[i] && a != 0) begin
          ed = m_regs[a];
          eb = m_busy[a];
`ifdef REGFILE_BYPASS_EN
          for (int j = 0; j < NWR; j++) begin
            if (bus.wr_en[j] && int'(bus.wr_addr[j*AW +: AW]) == a) begin
              ed = bus.wr_data[j*XLEN +: XLEN];
              eb = 1'b0;
            end
          end
`endif
        end
        chk($sformatf("rd_data[%0d]", i), bus.rd_data[i*XLEN +: XLEN], ed);
        chk($sformatf("rd_busy[%0d]", i), {31'b0, bus.rd_busy[i]}, {31'b0, eb});
      end
    end
  end

  task automatic idle();
    bus.rd_en      = '0;
    bus.rd_addr    = '0;
    bus.wr_en      = '0;
    bus.wr_addr    = '0;
    bus.wr_data    = '0;
    bus.alloc_en   = 1'b0;
    bus.alloc_addr = '0;
  endtask

  task automatic set_wr(input int p, input int a, input logic [31:0] d);
    logic [31:0] av;
    av = a;
    bus.wr_en[p]              = 1'b1;
    bus.wr_addr[p*AW +: AW]   = av[AW-1:0];
    bus.wr_data[p*XLEN +: XLEN] = d;
  endtask

  task automatic set_rd(input int p, input int a);
    logic [31:0] av;
    av = a;
    bus.rd_en[p]            = 1'b1;
    bus.rd_addr[p*AW +: AW] = av[AW-1:0];
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    step();
    rst = 1'b0;

    // INIT: ready low for exactly NREGS cycles; a write in the 5th is ignored
    for (int k = 0; k < NREGS; k++) begin
      idle();
      if (k == 4) set_wr(0, 5, 32'hFFFF_FFFF);
      @(negedge clk);
      chk("init_ready_low", {31'b0, bus.ready}, 32'd0);
      step();
    end
    idle();
    set_rd(0, 5);
    set_rd(1, 5);
    @(negedge clk);
    chk("init_ready_high", {31'b0, bus.ready}, 32'd1);
    chk("init_x5_p0", bus.rd_data[31:0], 32'd0);
    step();

    idle();
    set_wr(0, 5, 32'hDEAD_BEEF);
    step();
    idle();
    set_rd(0, 5);
    set_rd(1, 5);
    @(negedge clk);
    chk("x5_p0", bus.rd_data[31:0], 32'hDEAD_BEEF);
    chk("x5_p1", bus.rd_data[63:32], 32'hDEAD_BEEF);
    step();

    idle();
    set_wr(1, 0, 32'h0000_1234);
    step();
    idle();
    set_rd(0, 0);
    @(negedge clk);
    chk("x0_zero", bus.rd_data[31:0], 32'd0);
    step();

    idle();
    set_wr(0, 7, 32'h11);
    set_wr(1, 7, 32'h22);
    step();
    idle();
    set_rd(1, 7);
    @(negedge clk);
    chk("x7_prio", bus.rd_data[63:32], 32'h22);
    step();

    idle();
    set_wr(0, 9, 32'hA5A5_A5A5);
    set_rd(0, 9);
    @(negedge clk);
`ifdef REGFILE_BYPASS_EN
    chk("x9_bypass", bus.rd_data[31:0], 32'hA5A5_A5A5);
`else
    chk("x9_nobypass", bus.rd_data[31:0], 32'd0);
`endif
    step();

    idle();
    bus.alloc_en   = 1'b1;
    bus.alloc_addr = 5'd3;
    step();
    idle();
    set_rd(0, 3);
    bus.rd_addr[2*AW-1:AW] = 5'd3;
    @(negedge clk);
    chk("x3_busy", {31'b0, bus.rd_busy[0]}, 32'd1);
    chk("x3_rden0_busy", {31'b0, bus.rd_busy[1]}, 32'd0);
    set_wr(0, 3, 32'h33);
    step();
    idle();
    set_rd(0, 3);
    @(negedge clk);
    chk("x3_wb_clear", {31'b0, bus.rd_busy[0]}, 32'd0);
    set_wr(1, 3, 32'h44);
    bus.alloc_en   = 1'b1;
    bus.alloc_addr = 5'd3;
    step();
    idle();
    set_rd(0, 3);
    @(negedge clk);
    chk("x3_alloc_wins", {31'b0, bus.rd_busy[0]}, 32'd1);
    chk("x3_data", bus.rd_data[31:0], 32'h44);
    step();

    idle();
    set_wr(0, 4, 32'h55);
    bus.alloc_en   = 1'b1;
    bus.alloc_addr = 5'd4;
    step();
    idle();
    set_rd(0, 4);
    @(negedge clk);
    chk("x4_pre_data", bus.rd_data[31:0], 32'h55);
    chk("x4_pre_busy", {31'b0, bus.rd_busy[0]}, 32'd1);
    rst = 1'b1;
    set_wr(1, 6, 32'h77);
    step();
    rst = 1'b0;
    idle();
    set_rd(0, 4);
    set_rd(1, 6);
    @(negedge clk);
    chk("rst_ready", {31'b0, bus.ready}, 32'd0);
    chk("rst_busy", {31'b0, bus.rd_busy[0]}, 32'd0);
    repeat (NREGS) step();
    @(negedge clk);
    chk("rst_ready_back", {31'b0, bus.ready}, 32'd1);
    chk("rst_x4_zero", bus.rd_data[31:0], 32'd0);
    chk("rst_x6_zero", bus.rd_data[63:32], 32'd0);
    chk("rst_x4_idle", {31'b0, bus.rd_busy[0]}, 32'd0);
    step();

    for (int n = 0; n < 3000; n++) begin
      rst            = ($urandom_range(0, 299) == 0);
      bus.rd_en      = NRD'($urandom);
      bus.wr_en      = NWR'($urandom);
      bus.alloc_en   = ($urandom_range(0, 2) == 0);
      bus.alloc_addr = AW'($urandom_range(0, 7));
      for (int i = 0; i < NRD; i++) bus.rd_addr[i*AW +: AW] = AW'($urandom_range(0, 7));
      for (int j = 0; j < NWR; j++) begin
        bus.wr_addr[j*AW +: AW]     = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
        bus.wr_data[j*XLEN +: XLEN] = $urandom;
      end
      step();
    end
    rst = 1'b0;
    idle();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port integer register file with a per-register busy scoreboard, for the ID/WB stages of the pipelined core. It provides NRD read ports and NWR write ports, optional same-cycle write-to-read bypass, and a hardwired-zero register. After reset, a sequential init engine clears the array one entry per cycle, so no large reset fan-out is needed. The scoreboard lets ID stall on operands whose producer has issued but not yet written back.

## Interface
- XLEN, 32, data width
- NREGS, 32, register count (power of two, ≥2); AW = $clog2(NREGS)
- NRD, 2, read ports
- NWR, 2, write ports; higher index has priority
- ZERO_REG, 1, 1 = register 0 reads 0 and ignores writes/alloc
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- rd_en  in  NRD  per-port read enable
- rd_addr  in  NRD*AW  read addresses; port i at [i*AW +: AW]
- rd_data  out  NRD*XLEN  read data; port i at [i*XLEN +: XLEN]
- rd_busy  out  NRD  operand has pending producer
- wr_en  in  NWR  per-port write enable
- wr_addr  in  NWR*AW  write addresses
- wr_data  in  NWR*XLEN  write data
- alloc_en  in  1  mark alloc_addr busy (issue of instruction writing it)
- alloc_addr  in  AW  destination being allocated
- ready  out  1  init complete; array usable

## Operation
- FSM states: INIT, RUN. rst high at a clock edge → INIT, init counter cnt=0, all busy bits cleared at that edge.
- INIT: each cycle writes 0 to reg[cnt] and increments cnt; at the edge where cnt==NREGS-1, write 0 and go to RUN. Writes and alloc are ignored in INIT; ready=0, rd_data=0, rd_busy=0.
- RUN: ready=1. A write with wr_en[j] stores wr_data[j] into reg[wr_addr[j]] at the clock edge. If several ports target the same address, the highest-indexed port wins. With ZERO_REG=1, writes to address 0 are dropped.
- Read: rd_en[i]=0 → rd_data[i]=0, rd_busy[i]=0. Otherwise rd_data[i]=reg[rd_addr[i]] (subject to bypass, see Configuration). With ZERO_REG=1, address 0 always reads 0 and is never busy.
- Scoreboard: busy[a] clears at the edge where any write port writes a, and is set at the edge where alloc_en targets a. When alloc and a write hit the same address in one cycle, alloc wins and busy ends at 1, because it reflects the new producer. Alloc of register 0 with ZERO_REG=1 is ignored.
- rd_busy[i] = busy[rd_addr[i]], masked by bypass as described below.
- rst asserted mid-RUN or mid-INIT: INIT restarts at cnt=0, and ready drops in the cycle after the rst edge. Writes in the rst cycle are discarded.

## Timing
- Reset values after the rst edge: ready=0, rd_data=0, rd_busy=0, all busy=0.
- ready rises NREGS cycles after the last clock edge with rst high.
- Write latency: 1 edge, visible to a non-bypassed read in the next cycle.
- Read path is fully combinational; there is no read latency.
- Alloc sets busy at the edge, visible on rd_busy in the next cycle.
- rd_data, rd_busy and ready depend only on state and current-cycle inputs; there is no handshake.

## Configuration
- REGFILE_BYPASS_EN defined: if rd_en[i] is set and rd_addr[i] matches a same-cycle write (wr_en[j], wr_addr[j], nonzero address when ZERO_REG=1), then rd_data[i] takes the highest-indexed matching wr_data[j] and rd_busy[i]=0. Bypass is gated by ready.
- REGFILE_BYPASS_EN undefined: reads always return the stored value (the old value during a same-cycle write), and rd_busy reflects the stored busy bit.

## Test plan
- Init: pulse rst 1 cycle with NREGS=32 → ready=0 for exactly 32 cycles then 1; every rd_data=0 after that; a write in the 5th INIT cycle has no effect.
- Write/read: write 0xDEADBEEF to x5 via port 0 → next cycle a read of x5 on both read ports gives 0xDEADBEEF. Write 0x1234 to x0 → x0 still reads 0.
- Port conflict: in one cycle, wr port0 writes x7=0x11 and port1 writes x7=0x22 → x7 reads 0x22.
- Bypass: write x9=0xA5A5A5A5 while reading x9 with old value 0 → rd_data=0xA5A5A5A5 with REGFILE_BYPASS_EN defined, 0 without it.
- Scoreboard: alloc x3 → rd_busy=1 from next cycle. Writeback x3 → busy clears. Alloc x3 and write x3 in the same cycle → busy stays 1. Reading with rd_en=0 → rd_busy=0.
- Reset mid-op: assert rst while x4=0x55 and x4 is busy → ready=0 and busy cleared next cycle; after 32 cycles x4 reads 0.
